aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-schedule generator: takes a 128-bit cipher key and produces all 11 round keys (FIPS-197 KeyExpansion), one round key per clock. Sits directly upstream of `encryption` and `decryption`. Its packed schedule drives their `w` input, and its `key` pass-through drives their `key` input. It replaces the practice of supplying the schedule from the bench.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request expansion of `key`; sampled only in IDLE or DONE
- key  in  128  cipher key, FIPS byte order (byte 0 in bits [127:120]); sampled on the accepted `start` edge
- busy  out  1  high while expanding
- done  out  1  one-cycle pulse when the schedule is complete
- valid  out  1  level; `w` holds a complete schedule for the last accepted key
- w  out  1408  packed schedule: round 0 in [1407:1280] … round 10 in [127:0]
- rk_sel  in  4  round-key read index 0..10
- rk  out  128  registered round key `w` slice for `rk_sel`; 0 if `rk_sel` > 10

## Operation
- FSM states and transitions:
  - IDLE: `start`=1 → EXPAND.
  - EXPAND: runs 10 cycles, then → DONE.
  - DONE: `start`=1 → EXPAND; otherwise stay in DONE.
  - rst → IDLE from any state.
- Accepted `start` edge:
  - Round 0 slice = `key`.
  - Round counter r = 1.
  - `valid` cleared.
  - `busy`=1.
- Each EXPAND edge:
  - Computes round key r from round key r−1.
  - Stores it in slice r and increments r.
- Round computation, with words W0..W3 of the previous key (W0 = MSBs):
  - t = SubWord(RotWord(W3)) ^ {Rcon[r], 24'h0}
  - N0 = W0^t
  - N1 = W1^N0
  - N2 = W2^N1
  - N3 = W3^N2
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. The Rcon table is GF(2^8) constants; no carry/overflow logic is involved.
- SubWord uses four instances of the team forward S-box; only one round is computed per cycle, so no S-box sharing is needed.
- `start` in EXPAND is ignored; no queuing, and the `key` change has no effect.
- `start` in DONE restarts expansion: `valid` drops on the accept edge, and stale slices 1..10 remain visible until overwritten.
- `key` is only captured at accept; later changes to `key` do not affect the schedule.

## Timing
- Reset values:
  - state IDLE, r=0
  - `busy`=0, `done`=0, `valid`=0
  - `w`=0, `rk`=0
- `start` accepted at edge E0:
  - E0: slice 0 written, `busy`=1.
  - E1..E10: slices 1..10 written.
  - E10: `done`=1 for exactly one cycle, `valid`=1, `busy`=0, state DONE.
- Latency: 10 cycles from accept to `done`/`valid`; throughput is one key per 11 cycles when `start` is held high (DONE accepts on the cycle after E10).
- `rk`: registered, so `rk` = slice(`rk_sel`) sampled at the previous edge (1-cycle read latency). It reflects in-flight writes one cycle later.
- rst mid-expansion clears everything on that edge: no `done` pulse, `valid`=0, `w`=0.
- rst and `start` asserted in the same cycle: rst wins and `start` is dropped.

## Test plan
- Reset: assert rst 2 cycles with `start`=1 → `busy`/`done`/`valid`=0, `w`=0, `rk`=0 throughout, no expansion.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `start` 1 cycle → `done` exactly 10 cycles after accept, then:
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - feeding `w` to `encryption` with msg 6bc1bee22e409f96e93d7e117393172a gives 3ad77bb40d7a3660a89ecaf32466ef97
- Zero key → round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; `rk_sel` sweep 0..15 returns slices 0..10, then 0.
- Pulse `start` with a new key during EXPAND → ignored; schedule matches the first key; single `done` pulse.
- Back-to-back: hold `start`=1 with the FIPS key, then switch to the zero key after the first `done` → second `done` 11 cycles after the first; `valid` low for 10 cycles between; final `w` = zero-key schedule.
- rst asserted at E5 → no `done`, all outputs 0; a subsequent `start` expands correctly from scratch.

Source files
------------

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-slice store,
// with a packed schedule output and a registered round-key read port.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv_b;

  always_comb begin
    inv_b  = gf_inv(data_i);
    data_o = inv_b ^ {inv_b[6:0], inv_b[7]} ^ {inv_b[5:0], inv_b[7:6]}
           ^ {inv_b[4:0], inv_b[7:5]} ^ {inv_b[3:0], inv_b[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expand (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  key,
  output logic          busy,
  output logic          done,
  output logic          valid,
  output logic [1407:0] w,
  input  logic [3:0]    rk_sel,
  output logic [127:0]  rk
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q;
  logic [127:0] slice_q [0:10];
  logic         done_q, valid_q;
  logic [127:0] rk_q;
  logic         accept;
  logic [127:0] prev_key, next_key;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [7:0]   rcon;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        accept  = 1'b1;
        state_d = ST_EXPAND;
      end
      ST_EXPAND: if (rnd_q == 4'd10) state_d = ST_DONE;
      ST_DONE: if (start) begin
        accept  = 1'b1;
        state_d = ST_EXPAND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 11; i++)
      if (4'(i + 1) == rnd_q) prev_key = slice_q[i];
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.data_i(rot_w[8*g +: 8]), .data_o(sub_w[8*g +: 8]));
  end

  assign t_w = sub_w ^ {rcon, 24'h0};
  assign next_key[127:96] = prev_key[127:96] ^ t_w;
  assign next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      rk_q    <= '0;
      for (int i = 0; i < 11; i++) slice_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        slice_q[0] <= key;
        rnd_q      <= 4'd1;
        valid_q    <= 1'b0;
      end else if (state_q == ST_EXPAND) begin
        for (int i = 1; i < 11; i++)
          if (4'(i) == rnd_q) slice_q[i] <= next_key;
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end
      // Read port sees the slice contents before this edge's write.
      rk_q <= '0;
      for (int i = 0; i < 11; i++)
        if (4'(i) == rk_sel) rk_q <= slice_q[i];
    end
  end

  for (genvar g = 0; g < 11; g++) begin : g_pack
    assign w[1407 - 128*g -: 128] = slice_q[g];
  end

  assign busy  = (state_q == ST_EXPAND);
  assign done  = done_q;
  assign valid = valid_q;
  assign rk    = rk_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed + randomized checks of aes_key_expand against a word-level FIPS-197 KeyExpansion model.
module tb_aes_key_expand;
  logic          clk = 1'b0;
  logic          rst, start;
  logic [127:0]  key;
  logic          busy, done, valid;
  logic [1407:0] w;
  logic [3:0]    rk_sel;
  logic [127:0]  rk;

  int tests = 0;
  int fails = 0;

  logic [127:0] exp_rk [11];
  logic [7:0]   sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy), .done(done),
    .valid(valid), .w(w), .rk_sel(rk_sel), .rk(rk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // FIPS-197 word-oriented KeyExpansion, Nk=4.
  task automatic model_expand(input logic [127:0] k);
    logic [31:0] ww [44];
    logic [31:0] tmp;
    logic [8:0]  rc;
    rc = 9'h001;
    for (int i = 0; i < 4; i++) ww[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = ww[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc[7:0], 24'h0};
        rc  = rc << 1;
        if (rc[8]) rc = rc ^ 9'h11b;
      end
      ww[i] = ww[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
  endtask

  task automatic check_sched(input string tag);
    for (int s = 0; s < 11; s++)
      check($sformatf("%s_slice%0d", tag, s), w[1407 - 128*s -: 128], exp_rk[s]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), '0);
    check({tag, "_done"}, 128'(done), '0);
    check({tag, "_valid"}, 128'(valid), '0);
    check({tag, "_rk"}, rk, '0);
    for (int s = 0; s < 11; s++)
      check($sformatf("%s_w%0d", tag, s), w[1407 - 128*s -: 128], '0);
  endtask

  // Pulse start with k, wait (bounded) for done and check latency and state around it.
  task automatic run_key(input string tag, input logic [127:0] k);
    int lat;
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_e0"}, 128'(busy), 128'd1);
    check({tag, "_valid_e0"}, 128'(valid), '0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_valid"}, 128'(valid), 128'd1);
    check({tag, "_busy_end"}, 128'(busy), '0);
    model_expand(k);
    check_sched(tag);
    tick();
    check({tag, "_done_pulse"}, 128'(done), '0);
  endtask

  initial begin
    logic [127:0] k1, k2;
    int dcnt, dfirst, gap, vlow;

    rst = 1'b1; start = 1'b1; rk_sel = '0;
    key = {$urandom, $urandom, $urandom, $urandom};
    tick();
    check_all_zero("rst_c1");
    tick();
    check_all_zero("rst_c2");
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle_busy", 128'(busy), '0);

    run_key("fips", FIPS_KEY);
    check("fips_r1", w[1279:1152], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r10", w[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key("zero", '0);
    check("zero_r1", w[1279:1152], 128'h62636363626363636263636362636363);
    check("zero_r10", w[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    for (int s = 0; s < 16; s++) begin
      rk_sel = 4'(s);
      tick();
      check($sformatf("rk_sel%0d", s), rk, (s <= 10) ? exp_rk[s] : 128'd0);
    end

    for (int t = 0; t < 3; t++)
      run_key($sformatf("rand%0d", t), {$urandom, $urandom, $urandom, $urandom});

    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    key = k1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    key = k2; start = 1'b1;
    tick();
    start = 1'b0; key = {$urandom, $urandom, $urandom, $urandom};
    dcnt = 0; dfirst = -1;
    for (int n = 5; n <= 20; n++) begin
      tick();
      if (done) begin
        dcnt++;
        if (dfirst < 0) dfirst = n;
      end
    end
    check("ign_done_count", 128'(dcnt), 128'd1);
    check("ign_done_cycle", 128'(dfirst), 128'd10);
    model_expand(k1);
    check_sched("ign");

    key = FIPS_KEY; start = 1'b1;
    tick();
    gap = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done) begin
        gap = n;
        break;
      end
    end
    check("b2b_first_latency", 128'(gap), 128'd10);
    key = '0;
    gap = -1; vlow = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!valid) vlow++;
      if (done) begin
        gap = n;
        break;
      end
    end
    start = 1'b0;
    check("b2b_gap", 128'(gap), 128'd11);
    check("b2b_valid_low", 128'(vlow), 128'd10);
    tick();
    model_expand('0);
    check_sched("b2b");

    key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    dcnt = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done || busy) dcnt++;
    end
    check("midrst_quiet", 128'(dcnt), '0);
    run_key("after_rst", {$urandom, $urandom, $urandom, $urandom});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
